// File: rtl/power_pkg.sv
// Shared types for the peripheral power scheduler and the power FSM array.
// Also holds the pointer-width helper used by the scheduler and its arbiter.
package power_pkg;

   typedef enum logic [1:0] {
      ACTIVE = 2'b00,
      IDLE   = 2'b01,
      SLEEP  = 2'b10
   } pwr_state_e;

   typedef enum logic [1:0] {
      READY,
      GRANT,
      SETTLE
   } sched_state_e;

   function automatic int ptr_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/power_wake_sched_if.sv
// Control/status bundle between the PM registers, the wake scheduler and the FSM array.
// The master side drives enables/requests; the slave side (scheduler) drives status.
interface power_wake_sched_if #(
   parameter int N      = 4,
   parameter int IDLE_W = 8
);
   logic [N-1:0]        enable;
   logic [N-1:0]        busy;
   logic [N-1:0]        wake_req;
   logic [IDLE_W-1:0]   idle_thresh;
   logic [N-1:0][1:0]   fsm_state;
   logic [N-1:0]        periph_en;
   logic [N-1:0]        sleep_eligible;
   logic [N-1:0]        wake_evt;
   logic [N-1:0]        wake_pending;
   logic                sched_busy;

   modport master (
      output enable, busy, wake_req, idle_thresh, fsm_state,
      input  periph_en, sleep_eligible, wake_evt, wake_pending, sched_busy
   );

   modport slave (
      input  enable, busy, wake_req, idle_thresh, fsm_state,
      output periph_en, sleep_eligible, wake_evt, wake_pending, sched_busy
   );
endinterface

// File: rtl/power_rr_arb.sv
// Combinational N-way round-robin arbiter: grants the first request at or after ptr,
// wrapping modulo N. The pointer register lives in the parent.
module power_rr_arb #(
   parameter int N  = 4,
   parameter int PW = 2
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  gnt,
   output logic          valid
);

   int            idx;
   logic [PW-1:0] sel;

   always_comb begin
      gnt   = '0;
      valid = 1'b0;
      idx   = 0;
      sel   = '0;
      for (int k = 0; k < N; k++) begin
         idx = int'(ptr) + k;
         if (idx >= N) idx = idx - N;
         sel = PW'(idx);
         if (!valid && req[sel]) begin
            gnt[sel] = 1'b1;
            valid    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/power_wake_sched.sv
// Wake scheduler: idle tracking, enable registering and one-at-a-time round-robin wake pulses.
// Define PWR_SCHED_SETTLE_EN to build the post-grant inrush settle window (SETTLE_CYC cycles).
module power_wake_sched
   import power_pkg::*;
#(
   parameter int N          = 4,
   parameter int IDLE_W     = 8,
   parameter int SETTLE_CYC = 4
) (
   input  logic              clk,
   input  logic              rst,
   power_wake_sched_if.slave bus
);

   localparam int PW = ptr_w(N);

   if (SETTLE_CYC < 1) begin : g_settle_chk
      $error("SETTLE_CYC must be at least 1");
   end

   sched_state_e  state_reg, state_next;
   logic [PW-1:0] ptr_reg, ptr_next, win_idx;
   logic [N-1:0]  evt_reg, evt_next;
   logic [N-1:0]  pend_reg, pend_next, pend_set, pend_clr;
   logic [N-1:0]  en_reg, elig_reg, elig_next;
   logic [N-1:0]  arb_gnt;
   logic          arb_valid;

`ifdef PWR_SCHED_SETTLE_EN
   localparam int SW = (SETTLE_CYC > 2) ? $clog2(SETTLE_CYC) : 1;
   logic [SW-1:0] settle_reg, settle_next;
`endif

   // Per-peripheral idle counter and pending set condition
   for (genvar gi = 0; gi < N; gi++) begin : g_periph
      logic [IDLE_W-1:0] cnt_reg, cnt_next;
      logic              cnt_clr;

      assign cnt_clr  = bus.busy[gi] || !bus.enable[gi] || evt_reg[gi];
      assign cnt_next = cnt_clr ? '0 :
                        (cnt_reg >= bus.idle_thresh) ? bus.idle_thresh : cnt_reg + 1'b1;
      assign elig_next[gi] = bus.enable[gi] && !bus.busy[gi] && (cnt_reg == bus.idle_thresh);
      assign pend_set[gi]  = bus.wake_req[gi] && bus.enable[gi] && (bus.fsm_state[gi] != ACTIVE);

      always_ff @(posedge clk or posedge rst) begin
         if (rst) cnt_reg <= '0;
         else     cnt_reg <= cnt_next;
      end
   end

   // Clear beats set, so a request arriving during its own grant cycle is not re-queued
   assign pend_clr  = ~bus.enable | ((state_reg == GRANT) ? evt_reg : '0);
   assign pend_next = (pend_reg | pend_set) & ~pend_clr;

   power_rr_arb #(.N(N), .PW(PW)) u_arb (
      .req   (pend_reg),
      .ptr   (ptr_reg),
      .gnt   (arb_gnt),
      .valid (arb_valid)
   );

   always_comb begin
      win_idx = '0;
      for (int i = 0; i < N; i++) begin
         if (evt_reg[i]) win_idx = PW'(i);
      end
   end

   always_comb begin
      state_next = state_reg;
      ptr_next   = ptr_reg;
      evt_next   = '0;
`ifdef PWR_SCHED_SETTLE_EN
      settle_next = settle_reg;
`endif
      case (state_reg)
         READY: begin
            if (arb_valid) begin
               state_next = GRANT;
               evt_next   = arb_gnt;
            end
         end
         GRANT: begin
            ptr_next = (win_idx == PW'(N - 1)) ? '0 : win_idx + 1'b1;
`ifdef PWR_SCHED_SETTLE_EN
            state_next  = SETTLE;
            settle_next = SW'(SETTLE_CYC - 1);
`else
            state_next  = READY;
`endif
         end
`ifdef PWR_SCHED_SETTLE_EN
         SETTLE: begin
            if (settle_reg == '0) state_next  = READY;
            else                  settle_next = settle_reg - 1'b1;
         end
`endif
         default: state_next = READY;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= READY;
         ptr_reg   <= '0;
         evt_reg   <= '0;
         pend_reg  <= '0;
         en_reg    <= '0;
         elig_reg  <= '0;
`ifdef PWR_SCHED_SETTLE_EN
         settle_reg <= '0;
`endif
      end else begin
         state_reg <= state_next;
         ptr_reg   <= ptr_next;
         evt_reg   <= evt_next;
         pend_reg  <= pend_next;
         en_reg    <= bus.enable;
         elig_reg  <= elig_next;
`ifdef PWR_SCHED_SETTLE_EN
         settle_reg <= settle_next;
`endif
      end
   end

   assign bus.periph_en      = en_reg;
   assign bus.sleep_eligible = elig_reg;
   assign bus.wake_evt       = evt_reg;
   assign bus.wake_pending   = pend_reg;
   assign bus.sched_busy     = (state_reg != READY);

endmodule
